// File: rtl/lamp_monitor.sv
// Traffic lamp safety monitor: passes validated lamp requests through and flashes all-red on faults.
// Define LAMP_MON_WATCHDOG_EN to build in the input-stall watchdog (fault code 11).
// state    | meaning
// NORMAL   | lamps follow the validated controller requests
// FAULT    | lamps flash red, fault_code holds the first cause
// RECOVER  | all-red hold for RECOVER_TICKS ticks before NORMAL
module lamp_monitor #(
    parameter int BLINK_TICKS   = 1,
    parameter int RECOVER_TICKS = 2,
    parameter int TIMEOUT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [2:0] light_A,
    input  logic [2:0] light_B,
    input  logic       clear,
    output logic [2:0] lamp_A,
    output logic [2:0] lamp_B,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [1:0] S_NORMAL  = 2'd0;
    localparam logic [1:0] S_FAULT   = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    localparam logic [2:0] LAMP_RED = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [2:0] r_lamp_A;
    logic [2:0] r_lamp_B;
    logic       r_fault;
    logic [1:0] r_code;
    logic [3:0] r_rec_cnt;
    logic [3:0] r_blink_cnt;
    logic       r_phase;

    logic       w_illegal;
    logic       w_conflict;
    logic       w_bad;
    logic [1:0] w_bad_code;
    logic       w_wd_fault;

    function automatic logic f_onehot(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    always_comb begin
        w_illegal  = !f_onehot(light_A) || !f_onehot(light_B);
        w_conflict = !w_illegal && (light_A != LAMP_RED) && (light_B != LAMP_RED);
        w_bad      = w_illegal || w_conflict;
        w_bad_code = w_illegal ? 2'b01 : 2'b10;
    end

`ifdef LAMP_MON_WATCHDOG_EN
    logic [3:0] r_wd;
    logic [5:0] r_prev;
    logic [3:0] w_wd_next;

    // An input change on the same cycle as a tick clears rather than counts.
    always_comb begin
        w_wd_next = r_wd;
        if ({light_A, light_B} != r_prev) begin
            w_wd_next = 4'd0;
        end else if (tick && (r_wd != 4'hF)) begin
            w_wd_next = r_wd + 4'd1;
        end
    end

    assign w_wd_fault = (r_state == S_NORMAL) && (w_wd_next >= 4'(TIMEOUT_TICKS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wd   <= 4'd0;
            r_prev <= {light_A, light_B};
        end else begin
            r_prev <= {light_A, light_B};
            r_wd   <= ((w_state_next == r_state) && (r_state != S_FAULT)) ? w_wd_next : 4'd0;
        end
    end
`else
    logic [3:0] w_unused_timeout;
    assign w_unused_timeout = 4'(TIMEOUT_TICKS);
    assign w_wd_fault       = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_NORMAL: begin
                if (w_bad || w_wd_fault) begin
                    w_state_next = S_FAULT;
                end
            end
            S_FAULT: begin
                if (clear && !w_bad) begin
                    w_state_next = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (w_bad) begin
                    w_state_next = S_FAULT;
                end else if (tick && (r_rec_cnt == 4'(RECOVER_TICKS - 1))) begin
                    w_state_next = S_NORMAL;
                end
            end
            default: w_state_next = S_RECOVER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_RECOVER;
            r_lamp_A    <= LAMP_RED;
            r_lamp_B    <= LAMP_RED;
            r_fault     <= 1'b0;
            r_code      <= 2'b00;
            r_rec_cnt   <= 4'd0;
            r_blink_cnt <= 4'd0;
            r_phase     <= 1'b1;
        end else begin
            r_state <= w_state_next;
            case (w_state_next)
                S_NORMAL: begin
                    r_lamp_A <= light_A;
                    r_lamp_B <= light_B;
                    r_fault  <= 1'b0;
                    r_code   <= 2'b00;
                end
                S_RECOVER: begin
                    r_lamp_A <= LAMP_RED;
                    r_lamp_B <= LAMP_RED;
                    r_fault  <= 1'b0;
                    r_code   <= 2'b00;
                    if (r_state != S_RECOVER) begin
                        r_rec_cnt <= 4'd0;
                    end else if (tick) begin
                        r_rec_cnt <= r_rec_cnt + 4'd1;
                    end
                end
                S_FAULT: begin
                    r_fault <= 1'b1;
                    if (r_state != S_FAULT) begin
                        r_code      <= w_bad ? w_bad_code : 2'b11;
                        r_phase     <= 1'b1;
                        r_blink_cnt <= 4'd0;
                        r_lamp_A    <= LAMP_RED;
                        r_lamp_B    <= LAMP_RED;
                    end else if (tick) begin
                        if (r_blink_cnt == 4'(BLINK_TICKS - 1)) begin
                            r_blink_cnt <= 4'd0;
                            r_phase     <= !r_phase;
                            r_lamp_A    <= r_phase ? LAMP_OFF : LAMP_RED;
                            r_lamp_B    <= r_phase ? LAMP_OFF : LAMP_RED;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_lamp_A <= LAMP_RED;
                    r_lamp_B <= LAMP_RED;
                end
            endcase
        end
    end

    assign lamp_A     = r_lamp_A;
    assign lamp_B     = r_lamp_B;
    assign fault      = r_fault;
    assign fault_code = r_code;

endmodule

// File: tb/tb_lamp_monitor.sv
// Self-checking bench for lamp_monitor: directed scenarios plus random traffic against a tick-counting model.
module tb_lamp_monitor;

    localparam int BT = 1;
    localparam int RT = 2;
    localparam int TT = 8;
`ifdef LAMP_MON_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] light_A = 3'b001;
    logic [2:0] light_B = 3'b001;
    logic [2:0] lamp_A;
    logic [2:0] lamp_B;
    logic       fault;
    logic [1:0] fault_code;
    logic [8:0] obs;

    int errors = 0;
    int checks = 0;

    lamp_monitor #(
        .BLINK_TICKS  (BT),
        .RECOVER_TICKS(RT),
        .TIMEOUT_TICKS(TT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .light_A   (light_A),
        .light_B   (light_B),
        .clear     (clear),
        .lamp_A    (lamp_A),
        .lamp_B    (lamp_B),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    assign obs = {lamp_A, lamp_B, fault, fault_code};

    // Reference model: mode 0 normal, 1 fault, 2 recover; durations counted as ticks since entry.
    int         m_mode = 2;
    int         m_ticks = 0;
    int         m_idle = 0;
    logic [5:0] m_prev = 6'b001001;
    logic [2:0] m_la = 3'b001;
    logic [2:0] m_lb = 3'b001;
    logic       m_fault = 1'b0;
    logic [1:0] m_code = 2'b00;

    function automatic bit legal(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    function automatic logic [8:0] expv();
        return {m_la, m_lb, m_fault, m_code};
    endfunction

    task automatic m_enter_fault(input logic [1:0] c);
        m_mode = 1; m_ticks = 0; m_idle = 0;
        m_fault = 1'b1; m_code = c; m_la = 3'b001; m_lb = 3'b001;
    endtask

    task automatic model_edge(input logic r, input logic t, input logic [2:0] a,
                              input logic [2:0] b, input logic c);
        bit         ill;
        bit         bad;
        logic [1:0] bcode;
        ill   = !legal(a) || !legal(b);
        bad   = ill || (a != 3'b001 && b != 3'b001);
        bcode = ill ? 2'b01 : 2'b10;
        if (!r) begin
            m_mode = 2; m_ticks = 0; m_idle = 0; m_prev = {a, b};
            m_la = 3'b001; m_lb = 3'b001; m_fault = 1'b0; m_code = 2'b00;
            return;
        end
        if (m_mode == 1) m_idle = 0;
        else if ({a, b} != m_prev) m_idle = 0;
        else if (t && m_idle < 15) m_idle = m_idle + 1;
        m_prev = {a, b};
        case (m_mode)
            0: begin
                if (bad) m_enter_fault(bcode);
                else if (WD_EN && m_idle >= TT) m_enter_fault(2'b11);
                else begin m_la = a; m_lb = b; end
            end
            1: begin
                if (c && !bad) begin
                    m_mode = 2; m_ticks = 0; m_fault = 1'b0; m_code = 2'b00;
                    m_la = 3'b001; m_lb = 3'b001;
                end else if (t) begin
                    m_ticks = m_ticks + 1;
                    m_la = (((m_ticks / BT) % 2) == 0) ? 3'b001 : 3'b000;
                    m_lb = m_la;
                end
            end
            default: begin
                if (bad) m_enter_fault(bcode);
                else begin
                    if (t) m_ticks = m_ticks + 1;
                    if (m_ticks == RT) begin
                        m_mode = 0; m_idle = 0; m_la = a; m_lb = b;
                    end else begin
                        m_la = 3'b001; m_lb = 3'b001;
                    end
                end
            end
        endcase
    endtask

    task automatic step(input logic r, input logic t, input logic [2:0] a,
                        input logic [2:0] b, input logic c);
        rst = r; tick = t; light_A = a; light_B = b; clear = c;
        @(posedge clk);
        model_edge(r, t, a, b, c);
        #1;
    endtask

    task automatic go_normal(input logic [2:0] a, input logic [2:0] b);
        step(1'b0, 1'b0, a, b, 1'b0);
        step(1'b0, 1'b0, a, b, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (m_mode == 0) break;
            step(1'b1, 1'b1, a, b, 1'b0);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 3'b111, 3'b000, 1'b1);
        step(1'b0, 1'b1, 3'b100, 3'b100, 1'b0);
        checks++;
        if (obs !== 9'b001_001_0_00) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs, 9'b001_001_0_00);
        end
    endtask

    task automatic test_normal();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i == 2 || i == 5), 3'b001, 3'b100, 1'b0);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL normal_pass cyc%0d: got %b expected %b", i, obs, expv());
            end
        end
        checks++;
        if ({lamp_A, lamp_B, fault} !== 7'b001_100_0) begin
            errors++;
            $display("FAIL normal_final: got %b expected %b", {lamp_A, lamp_B, fault}, 7'b001_100_0);
        end
    endtask

    task automatic test_conflict();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 2 == 1), 3'b100, 3'b100, 1'b0);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL conflict_blink cyc%0d: got %b expected %b", i, obs, expv());
            end
        end
        checks++;
        if ({fault, fault_code} !== 3'b1_10) begin
            errors++;
            $display("FAIL conflict_code: got %b expected %b", {fault, fault_code}, 3'b1_10);
        end
        step(1'b1, 1'b0, 3'b001, 3'b100, 1'b1);
        checks++;
        if (obs !== 9'b001_001_0_00) begin
            errors++;
            $display("FAIL conflict_clear: got %b expected %b", obs, 9'b001_001_0_00);
        end
    endtask

    task automatic test_illegal();
        go_normal(3'b001, 3'b100);
        for (int i = 0; i < 10; i++) begin
            if (i < 6) step(1'b1, (i % 2 == 0), 3'b011, 3'b100, 1'b0);
            else       step(1'b1, (i % 2 == 0), 3'b100, 3'b010, 1'b0);
            checks++;
            if (obs !== expv() || lamp_A === 3'b011) begin
                errors++;
                $display("FAIL illegal_seq cyc%0d: got %b expected %b", i, obs, expv());
            end
        end
        checks++;
        if (fault_code !== 2'b01) begin
            errors++;
            $display("FAIL illegal_code_held: got %b expected %b", fault_code, 2'b01);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 3'b110, 3'b100, 1'b1);
            checks++;
            if (fault !== 1'b1 || obs !== expv()) begin
                errors++;
                $display("FAIL clear_ignored cyc%0d: got %b expected %b", i, obs, expv());
            end
        end
        step(1'b1, 1'b0, 3'b001, 3'b100, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i % 2 == 1), 3'b001, 3'b100, 1'b0);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL clear_recover cyc%0d: got %b expected %b", i, obs, expv());
            end
        end
        checks++;
        if (obs !== 9'b001_100_0_00) begin
            errors++;
            $display("FAIL clear_to_normal: got %b expected %b", obs, 9'b001_100_0_00);
        end
    endtask

    task automatic test_watchdog();
        int n_ticks;
        int fault_at;
        go_normal(3'b001, 3'b100);
        n_ticks  = 0;
        fault_at = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (i % 2 == 1), 3'b001, 3'b100, 1'b0);
            if (i % 2 == 1) n_ticks++;
            if (fault === 1'b1 && fault_at == 0) fault_at = n_ticks;
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL watchdog_hold cyc%0d: got %b expected %b", i, obs, expv());
            end
        end
        checks++;
        if (fault_at !== (WD_EN ? TT : 0)) begin
            errors++;
            $display("FAIL watchdog_fault_tick: got %0d required %0d", fault_at, (WD_EN ? TT : 0));
        end
        go_normal(3'b001, 3'b100);
        for (int i = 0; i < 28; i++) begin
            if (i < 13) step(1'b1, (i % 2 == 0), 3'b001, 3'b100, 1'b0);
            else        step(1'b1, (i % 2 == 0), 3'b001, 3'b010, 1'b0);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL watchdog_change cyc%0d: got %b expected %b", i, obs, expv());
            end
        end
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_no_fault: got %b expected %b", fault, 1'b0);
        end
    endtask

    task automatic test_reset_mid_fault();
        step(1'b1, 1'b0, 3'b010, 3'b100, 1'b0);
        step(1'b1, 1'b1, 3'b010, 3'b100, 1'b0);
        checks++;
        if (obs !== 9'b000_000_1_10) begin
            errors++;
            $display("FAIL midfault_dark: got %b expected %b", obs, 9'b000_000_1_10);
        end
        step(1'b0, 1'b0, 3'b010, 3'b100, 1'b0);
        checks++;
        if (obs !== 9'b001_001_0_00) begin
            errors++;
            $display("FAIL midfault_reset: got %b expected %b", obs, 9'b001_001_0_00);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 3'b100, 3'b001, 1'b0);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL midfault_recover cyc%0d: got %b expected %b", i, obs, expv());
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] ra;
        logic [2:0] rb;
        int         k;
        ra = 3'b001;
        rb = 3'b100;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) < 7) begin
                k = $urandom_range(9);
                if (k < 6) begin
                    if ($urandom_range(1) == 0) begin
                        ra = 3'b001; rb = 3'b001 << $urandom_range(2);
                    end else begin
                        rb = 3'b001; ra = 3'b001 << $urandom_range(2);
                    end
                end else if (k < 8) begin
                    ra = 3'b010 << $urandom_range(1);
                    rb = 3'b010 << $urandom_range(1);
                end else begin
                    ra = 3'($urandom_range(7));
                    rb = 3'($urandom_range(7));
                end
            end
            step(($urandom_range(59) != 0), ($urandom_range(2) == 0), ra, rb,
                 ($urandom_range(3) == 0));
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL random cyc%0d: got %b expected %b", i, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_conflict();
        test_illegal();
        test_clear();
        test_watchdog();
        test_reset_mid_fault();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
